program_rom_loader: RTL

- Program-memory responder for the 8-bit CPU's instruction-fetch interface: serves a 16-bit `rom_value` for the CPU-driven `rom_address`.
- Contains a byte-serial loader (valid/ready) that fills the memory while holding the CPU in reset via `cpu_rst`.
- Releases the CPU once the load completes.
- Sits between the external program source (switch panel / upstream sequencer) and the CPU's `rst` and `rom_value` pins.

---
 rtl/program_rom_loader.sv | 108 ++++++++++
 1 files changed

// File: rtl/program_rom_loader.sv
// Program ROM for the 8-bit CPU: byte-serial loader that holds the CPU in reset
// until a load completes, plus a zero-latency fetch port. Optional checksum: ROM_CHECKSUM_EN.
module program_rom_loader #(
  parameter int unsigned ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_start,
  input  logic              load_valid,
  input  logic [7:0]        load_byte,
  input  logic              load_last,
  output logic              load_ready,
  input  logic [7:0]        rom_address,
  output logic [15:0]       rom_value,
  output logic              cpu_rst,
  output logic              load_done,
  output logic [ADDR_W:0]   words_loaded,
  output logic [7:0]        checksum
);

  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam int unsigned CNT_W = ADDR_W + 1;

  typedef enum logic [1:0] {IDLE, LOAD_LO, LOAD_HI, RUN} state_t;

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] word_ptr;
  logic [7:0]        lo_byte;
  logic [15:0]       mem [DEPTH];
  logic              accept;
  logic              last_word;
  logic              hi_write;

  assign accept    = load_valid && load_ready;
  assign last_word = load_last || (word_ptr == ADDR_W'(DEPTH - 1));
  assign hi_write  = accept && (state == LOAD_HI) && !load_start;

  // Next state; a restart overrides any byte accepted in the same cycle
  always_comb begin
    state_nxt = state;
    if (load_start) begin
      state_nxt = LOAD_LO;
    end else begin
      case (state)
        LOAD_LO: if (accept) state_nxt = LOAD_HI;
        LOAD_HI: if (accept) state_nxt = last_word ? RUN : LOAD_LO;
        default: state_nxt = state;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      cpu_rst      <= 1'b1;
      load_ready   <= 1'b0;
      load_done    <= 1'b0;
      words_loaded <= '0;
      lo_byte      <= 8'h00;
      word_ptr     <= '0;
    end else begin
      state      <= state_nxt;
      cpu_rst    <= (state_nxt != RUN);
      load_done  <= (state_nxt == RUN);
      load_ready <= (state_nxt == LOAD_LO) || (state_nxt == LOAD_HI);
      if (load_start) begin
        word_ptr     <= '0;
        words_loaded <= '0;
        lo_byte      <= 8'h00;
      end else if (accept && (state == LOAD_LO)) begin
        lo_byte <= load_byte;
      end else if (hi_write) begin
        words_loaded <= CNT_W'(word_ptr) + CNT_W'(1);
        if (!last_word) word_ptr <= word_ptr + ADDR_W'(1);
      end
    end
  end

  // Program storage is deliberately not reset so a CPU reset keeps the program
  always_ff @(posedge clk) begin
    if (hi_write) mem[word_ptr] <= {load_byte, lo_byte};
  end

  always_comb begin
    rom_value = 16'h0000;
    if ({1'b0, rom_address} < 9'(DEPTH)) rom_value = mem[rom_address[ADDR_W-1:0]];
  end

`ifdef ROM_CHECKSUM_EN
  logic [7:0] cks_acc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cks_acc <= 8'h00;
    end else if (load_start) begin
      cks_acc <= 8'h00;
    end else if (accept) begin
      cks_acc <= cks_acc + load_byte;
    end
  end

  assign checksum = cks_acc;
`else
  assign checksum = 8'h00;
`endif

endmodule
